ifid_pipe_reg: RTL

IFID_PIPE_REG -- requirements
Module: ifid_pipe_reg

---
 rtl/ifid_pkg.sv | 33 +++
 rtl/ifid_pipe_reg_if.sv | 42 ++++
 rtl/ifid_lane_slot.sv | 107 ++++++++++
 rtl/ifid_pipe_reg.sv | 133 +++++++++++++
 4 files changed

// File: rtl/ifid_pkg.sv
// rtl/ifid_pkg.sv - shared types and defaults for the IF/ID pipeline register
//
// Purpose: state encoding for the skid FSM, per-lane command encodings used
// between the shared control and each lane, and default geometry constants.
// Ports: none (package).
package ifid_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_LANES = 1;
  localparam int DEF_CNTW  = 16;

  // Skid slot occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ifid_state_e;

  // What each lane's decode-facing output register does at the next edge.
  typedef enum logic [1:0] {
    OUT_HOLD      = 2'd0,
    OUT_LOAD_IN   = 2'd1,
    OUT_LOAD_SLOT = 2'd2,
    OUT_CLEAR     = 2'd3
  } out_cmd_e;

  // What each lane's skid slot does at the next edge.
  typedef enum logic [1:0] {
    SLOT_HOLD    = 2'd0,
    SLOT_LOAD_IN = 2'd1,
    SLOT_CLEAR   = 2'd2
  } slot_cmd_e;

endpackage

// File: rtl/ifid_pipe_reg_if.sv
// rtl/ifid_pipe_reg_if.sv - fetch/decode bundle for the IF/ID pipeline register
//
// Purpose: groups the fetch-side inputs and decode-side outputs of
// ifid_pipe_reg.
// Signals:
//   en, flush            control shared by all lanes
//   valid_in/instr_in/pcplus_in     fetch word-set, lane 0 in LSBs
//   valid_out/instr_out/pcplus_out  registered word-set to decode
//   hold_full, overflow, stall_cnt  status
// Modports: master = stimulus/fetch side, slave = the pipeline register.
interface ifid_pipe_reg_if
  import ifid_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES,
  parameter int CNTW  = DEF_CNTW
) ();

  logic                   en;
  logic                   flush;
  logic [LANES-1:0]       valid_in;
  logic [LANES*WIDTH-1:0] instr_in;
  logic [LANES*WIDTH-1:0] pcplus_in;

  logic [LANES*WIDTH-1:0] instr_out;
  logic [LANES*WIDTH-1:0] pcplus_out;
  logic [LANES-1:0]       valid_out;
  logic                   hold_full;
  logic                   overflow;
  logic [CNTW-1:0]        stall_cnt;

  modport master (
    output en, flush, valid_in, instr_in, pcplus_in,
    input  instr_out, pcplus_out, valid_out, hold_full, overflow, stall_cnt
  );

  modport slave (
    input  en, flush, valid_in, instr_in, pcplus_in,
    output instr_out, pcplus_out, valid_out, hold_full, overflow, stall_cnt
  );

endinterface

// File: rtl/ifid_lane_slot.sv
// rtl/ifid_lane_slot.sv - one lane of output register plus skid slot
//
// Purpose: holds one lane's decode-facing register and its one-entry skid
// slot; all sequencing decisions come from the shared control as commands.
// Ports:
//   clk, clr                      clock, synchronous active-high reset
//   out_cmd_i, slot_cmd_i         per-edge commands from the shared FSM
//   valid_i, instr_i, pcplus_i    this lane's fetch inputs
//   valid_o, instr_o, pcplus_o    this lane's registered outputs
module ifid_lane_slot
  import ifid_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  out_cmd_e         out_cmd_i,
  input  slot_cmd_e        slot_cmd_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] instr_i,
  input  logic [WIDTH-1:0] pcplus_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] pcplus_o
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_instr_q, out_instr_d;
  logic [WIDTH-1:0] out_pcplus_q, out_pcplus_d;
  logic             slot_valid_q, slot_valid_d;
  logic [WIDTH-1:0] slot_instr_q, slot_instr_d;
  logic [WIDTH-1:0] slot_pcplus_q, slot_pcplus_d;

  // Data is masked at capture so an invalid lane never carries stale bits
  // into decode or into the slot.
  logic [WIDTH-1:0] in_instr_m;
  logic [WIDTH-1:0] in_pcplus_m;

  assign in_instr_m  = valid_i ? instr_i  : '0;
  assign in_pcplus_m = valid_i ? pcplus_i : '0;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pcplus_d = out_pcplus_q;
    unique case (out_cmd_i)
      OUT_LOAD_IN: begin
        out_valid_d  = valid_i;
        out_instr_d  = in_instr_m;
        out_pcplus_d = in_pcplus_m;
      end
      OUT_LOAD_SLOT: begin
        out_valid_d  = slot_valid_q;
        out_instr_d  = slot_instr_q;
        out_pcplus_d = slot_pcplus_q;
      end
      OUT_CLEAR: begin
        out_valid_d  = 1'b0;
        out_instr_d  = '0;
        out_pcplus_d = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    slot_valid_d  = slot_valid_q;
    slot_instr_d  = slot_instr_q;
    slot_pcplus_d = slot_pcplus_q;
    unique case (slot_cmd_i)
      SLOT_LOAD_IN: begin
        slot_valid_d  = valid_i;
        slot_instr_d  = in_instr_m;
        slot_pcplus_d = in_pcplus_m;
      end
      SLOT_CLEAR: begin
        slot_valid_d  = 1'b0;
        slot_instr_d  = '0;
        slot_pcplus_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_pcplus_q  <= '0;
      slot_valid_q  <= 1'b0;
      slot_instr_q  <= '0;
      slot_pcplus_q <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pcplus_q  <= out_pcplus_d;
      slot_valid_q  <= slot_valid_d;
      slot_instr_q  <= slot_instr_d;
      slot_pcplus_q <= slot_pcplus_d;
    end
  end

  assign valid_o  = out_valid_q;
  assign instr_o  = out_instr_q;
  assign pcplus_o = out_pcplus_q;

endmodule

// File: rtl/ifid_pipe_reg.sv
// rtl/ifid_pipe_reg.sv - multi-lane IF/ID pipeline register with one-entry skid
//
// Purpose: registers fetched instructions and PC+4 into decode. When decode
// stalls while the synchronous IMEM is still presenting data, that data is
// caught in a skid slot; a second arrival during the same stall is dropped
// and latched in a sticky overflow flag. Counts stalled cycles (saturating).
// Ports:
//   clk   rising-edge clock
//   clr   synchronous active-high reset, priority over flush and en
//   bus   ifid_pipe_reg_if.slave (en, flush, fetch inputs, decode outputs,
//         hold_full, overflow, stall_cnt)
module ifid_pipe_reg
  import ifid_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES,
  parameter int CNTW  = DEF_CNTW
) (
  input  logic            clk,
  input  logic            clr,
  ifid_pipe_reg_if.slave  bus
);

  ifid_state_e     state_q, state_d;
  logic            overflow_q, overflow_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

  out_cmd_e        out_cmd;
  slot_cmd_e       slot_cmd;
  logic            any_valid;

  assign any_valid = |bus.valid_in;

  // Shared control: one decision per edge, broadcast to every lane.
  always_comb begin
    state_d    = state_q;
    out_cmd    = OUT_HOLD;
    slot_cmd   = SLOT_HOLD;
    overflow_d = overflow_q;
    if (bus.flush) begin
      out_cmd  = OUT_CLEAR;
      slot_cmd = SLOT_CLEAR;
      state_d  = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (bus.en) begin
            out_cmd = OUT_LOAD_IN;
          end else if (any_valid) begin
            slot_cmd = SLOT_LOAD_IN;
            state_d  = FULL;
          end
        end
        FULL: begin
          if (bus.en) begin
            // Drain the slot; refilling it with zeros when nothing arrives
            // keeps an empty slot clean for the next capture.
            out_cmd  = OUT_LOAD_SLOT;
            slot_cmd = SLOT_LOAD_IN;
            state_d  = any_valid ? FULL : EMPTY;
          end else if (any_valid) begin
            overflow_d = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Stall counting is independent of flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!bus.en && (stall_cnt_q != {CNTW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= EMPTY;
      overflow_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      overflow_q  <= overflow_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  logic             lane_valid  [LANES];
  logic [WIDTH-1:0] lane_instr  [LANES];
  logic [WIDTH-1:0] lane_pcplus [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    ifid_lane_slot #(
      .WIDTH (WIDTH)
    ) u_lane (
      .clk        (clk),
      .clr        (clr),
      .out_cmd_i  (out_cmd),
      .slot_cmd_i (slot_cmd),
      .valid_i    (bus.valid_in[l]),
      .instr_i    (bus.instr_in[l*WIDTH +: WIDTH]),
      .pcplus_i   (bus.pcplus_in[l*WIDTH +: WIDTH]),
      .valid_o    (lane_valid[l]),
      .instr_o    (lane_instr[l]),
      .pcplus_o   (lane_pcplus[l])
    );
  end

  logic [LANES-1:0]       valid_out_w;
  logic [LANES*WIDTH-1:0] instr_out_w;
  logic [LANES*WIDTH-1:0] pcplus_out_w;

  always_comb begin
    valid_out_w  = '0;
    instr_out_w  = '0;
    pcplus_out_w = '0;
    for (int l = 0; l < LANES; l++) begin
      valid_out_w[l]                 = lane_valid[l];
      instr_out_w[l*WIDTH +: WIDTH]  = lane_instr[l];
      pcplus_out_w[l*WIDTH +: WIDTH] = lane_pcplus[l];
    end
  end

  assign bus.valid_out  = valid_out_w;
  assign bus.instr_out  = instr_out_w;
  assign bus.pcplus_out = pcplus_out_w;
  assign bus.hold_full  = (state_q == FULL);
  assign bus.overflow   = overflow_q;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule
